id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Decode-side operand stage and ID/EX pipeline register for the pipelined MIPS core. It drives the register file read addresses from the IF/ID instruction and captures the read data, with same-cycle write-back bypass. It also captures the control bus, sign-extended immediate and register specifiers into the ID/EX register. It detects load-use hazards, inserts bubbles, and honours EX-stage branch flushes.

Parameters:
- CTRL_W, 9, width of the control bus from the control unit. Bit map is defined in the package.
- CNT_W, 16, width of the saturating stall statistics counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous active-low reset, sampled on the i_clk rising edge.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  32  IF/ID instruction.
- id_pc4  in  32  IF/ID PC+4.
- id_ctrl  in  CTRL_W  control bus decoded from id_instr[31:26].
- regRdAddr1  out  5  equals id_instr[25:21]; combinational.
- regRdAddr2  out  5  equals id_instr[20:16]; combinational.
- regRdData1  in  32  register file read data, port 1.
- regRdData2  in  32  register file read data, port 2.
- wb_regWrEn  in  1  write-back write enable, snooped.
- wb_regWrAddr  in  5  write-back destination register.
- wb_regWrData  in  32  write-back data.
- ex_flush  in  1  branch or jump taken in EX; squash the instruction currently in ID.
- stall  out  1  hold PC and IF/ID this cycle; combinational.
- ex_valid  out  1  ID/EX register holds a real instruction.
- ex_ctrl  out  CTRL_W  registered control bus.
- ex_pc4  out  32  registered PC+4.
- ex_rd1  out  32  registered operand A.
- ex_rd2  out  32  registered operand B.
- ex_imm  out  32  registered sign-extended id_instr[15:0].
- ex_rs  out  5  registered rs specifier.
- ex_rt  out  5  registered rt specifier.
- ex_rd  out  5  registered rd specifier.
- stall_cnt  out  CNT_W  number of bubble-inserting stall cycles, saturating.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all ex_* outputs and stall_cnt go to 0. Reset takes priority over every other event.
- Write-back bypass, operand A: opA = wb_regWrData when wb_regWrEn=1, wb_regWrAddr equals rs, and rs is nonzero; otherwise opA = regRdData1.
- Write-back bypass, operand B: same rule using rt and regRdData2.
- Register $0 is never bypassed.
- The bypass is needed because the register file commits its write at the same edge that ID/EX captures, so a same-cycle read returns the old value.
- Hazard condition: all of ex_valid, ex_ctrl[MEMREAD], ex_ctrl[REGWRITE] and id_valid are 1, ex_rt is nonzero, and ex_rt equals id rs or id rt.
- The rt comparison is conservative: it applies whether or not the ID instruction uses rt.
- stall = hazard AND NOT ex_flush.
- Per-edge update priority:
  - Reset.
  - ex_flush: load a bubble.
  - hazard: load a bubble.
  - Otherwise load normally: ex_valid=id_valid, ex_ctrl=id_ctrl, operands opA/opB, ex_imm = sign-extension of id_instr[15:0], and ex_rs/ex_rt/ex_rd from bits [25:21], [20:16] and [15:11].
- Bubble: ex_valid=0 and ex_ctrl=0; data fields are don't-care and are implemented as hold.
- ex_ctrl bits are forced to 0 whenever id_valid=0, so an invalid slot never writes state.
- Latency: one cycle from the ID inputs to the ex_* outputs.
- A load-use pair costs exactly one bubble. On the next cycle ex_valid=0, so the hazard clears automatically.
- stall_cnt increments by 1 on each edge where stall=1 and reset is not active. It saturates at its all-ones value; no wrap.
- Simultaneous hazard and flush: flush wins. stall=0, and stall_cnt does not increment.

Decomposition:
- Package mips_pkg holds the control-bus bit indices: REGWRITE=0, MEMREAD=1, MEMWRITE=2, MEMTOREG=3, ALUSRC=4, REGDST=5, BRANCH=6, ALUOP=[8:7].
- The package also holds the instruction field position constants and the CTRL_W default.
- One sub-module is natural: hazard_detect, purely combinational, producing hazard from the ex and id specifiers.
- Bypass muxes, sign-extend and pipeline registers stay in the top module.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with random inputs -> every ex_* output and stall_cnt read 0. Release -> the first valid instruction appears on ex_* one cycle later.
- Same-cycle bypass: ID add $3,$1,$2 with regRdData1=5, while wb writes $1=0x1234 -> ex_rd1=0x1234, ex_rd2=regRdData2.
- Bypass to $0: wb write to $0 with data 0xFFFF and an ID instruction reading $0 -> ex_rd1=regRdData1, not 0xFFFF.
- Load-use: lw $4,0($1) followed by add $5,$4,$6 -> stall=1 for exactly one cycle, one bubble (ex_valid=0, ex_ctrl=0), add issues next cycle, stall_cnt=1.
- Flush during hazard: same load-use pair with ex_flush=1 in the hazard cycle -> stall=0, bubble loaded, stall_cnt unchanged.
- Sign-extend and saturation: imm 0x8001 -> ex_imm=0xFFFF8001. Force 2^16+3 stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: control-bus bit map and instruction field positions.
package mips_pkg;

   localparam int unsigned CTRL_W_DEF = 9;

   // Control-bus bit indices
   localparam int unsigned REGWRITE = 0;
   localparam int unsigned MEMREAD  = 1;
   localparam int unsigned MEMWRITE = 2;
   localparam int unsigned MEMTOREG = 3;
   localparam int unsigned ALUSRC   = 4;
   localparam int unsigned REGDST   = 5;
   localparam int unsigned BRANCH   = 6;
   localparam int unsigned ALUOP_LO = 7;
   localparam int unsigned ALUOP_HI = 8;

   // Instruction field positions
   localparam int unsigned REG_AW = 5;
   localparam int unsigned RS_LO  = 21;
   localparam int unsigned RT_LO  = 16;
   localparam int unsigned RD_LO  = 11;
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned OP_LO  = 26;

   function automatic logic [31:0] sign_ext16(input logic [IMM_W-1:0] imm);
      return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module hazard_detect
   import mips_pkg::*;
(
   input  logic              ex_valid_i,
   input  logic              ex_memread_i,
   input  logic              ex_regwrite_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   output logic              hazard_o
);

   logic load_in_ex;
   logic rt_match;

   always_comb begin
      load_in_ex = ex_valid_i && ex_memread_i && ex_regwrite_i && (ex_rt_i != '0);
      // rt is compared even when ID does not read it; a spare bubble is harmless
      rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
      hazard_o   = load_in_ex && id_valid_i && rt_match;
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode operand stage and ID/EX pipeline register with write-back bypass, load-use
// bubble insertion, EX flush handling and a saturating stall counter.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              id_valid,
   input  logic [31:0]       id_instr,
   input  logic [31:0]       id_pc4,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [4:0]        regRdAddr1,
   output logic [4:0]        regRdAddr2,
   input  logic [31:0]       regRdData1,
   input  logic [31:0]       regRdData2,
   input  logic              wb_regWrEn,
   input  logic [4:0]        wb_regWrAddr,
   input  logic [31:0]       wb_regWrData,
   input  logic              ex_flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_pc4,
   output logic [31:0]       ex_rd1,
   output logic [31:0]       ex_rd2,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic [31:0]       op_a, op_b;
   logic              hazard;
   logic [5:0]        unused_opcode;

   logic              ex_valid_q, ex_valid_d;
   logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
   logic [31:0]       ex_pc4_q, ex_pc4_d;
   logic [31:0]       ex_rd1_q, ex_rd1_d;
   logic [31:0]       ex_rd2_q, ex_rd2_d;
   logic [31:0]       ex_imm_q, ex_imm_d;
   logic [4:0]        ex_rs_q, ex_rs_d;
   logic [4:0]        ex_rt_q, ex_rt_d;
   logic [4:0]        ex_rd_q, ex_rd_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign id_rs         = id_instr[RS_LO +: REG_AW];
   assign id_rt         = id_instr[RT_LO +: REG_AW];
   assign id_rd         = id_instr[RD_LO +: REG_AW];
   assign unused_opcode = id_instr[OP_LO +: 6];
   assign regRdAddr1    = id_rs;
   assign regRdAddr2    = id_rt;

   hazard_detect u_hazard_detect (
      .ex_valid_i    (ex_valid_q),
      .ex_memread_i  (ex_ctrl_q[MEMREAD]),
      .ex_regwrite_i (ex_ctrl_q[REGWRITE]),
      .ex_rt_i       (ex_rt_q),
      .id_valid_i    (id_valid),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .hazard_o      (hazard)
   );

   assign stall = hazard && !ex_flush;

   // The register file commits on the same edge we capture, so forward WB data here
   always_comb begin
      op_a = regRdData1;
      op_b = regRdData2;
      if (wb_regWrEn && (wb_regWrAddr == id_rs) && (id_rs != '0)) op_a = wb_regWrData;
      if (wb_regWrEn && (wb_regWrAddr == id_rt) && (id_rt != '0)) op_b = wb_regWrData;
   end

   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_ctrl_d   = ex_ctrl_q;
      ex_pc4_d    = ex_pc4_q;
      ex_rd1_d    = ex_rd1_q;
      ex_rd2_d    = ex_rd2_q;
      ex_imm_d    = ex_imm_q;
      ex_rs_d     = ex_rs_q;
      ex_rt_d     = ex_rt_q;
      ex_rd_d     = ex_rd_q;
      stall_cnt_d = stall_cnt_q;

      if (ex_flush || hazard) begin
         ex_valid_d = 1'b0;
         ex_ctrl_d  = '0;
      end else begin
         ex_valid_d = id_valid;
         ex_ctrl_d  = id_valid ? id_ctrl : '0;
         ex_pc4_d   = id_pc4;
         ex_rd1_d   = op_a;
         ex_rd2_d   = op_b;
         ex_imm_d   = sign_ext16(id_instr[IMM_W-1:0]);
         ex_rs_d    = id_rs;
         ex_rt_d    = id_rt;
         ex_rd_d    = id_rd;
      end

      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= '0;
         ex_pc4_q    <= '0;
         ex_rd1_q    <= '0;
         ex_rd2_q    <= '0;
         ex_imm_q    <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_ctrl_q   <= ex_ctrl_d;
         ex_pc4_q    <= ex_pc4_d;
         ex_rd1_q    <= ex_rd1_d;
         ex_rd2_q    <= ex_rd2_d;
         ex_imm_q    <= ex_imm_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_rd_q     <= ex_rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_ctrl   = ex_ctrl_q;
   assign ex_pc4    = ex_pc4_q;
   assign ex_rd1    = ex_rd1_q;
   assign ex_rd2    = ex_rd2_q;
   assign ex_imm    = ex_imm_q;
   assign ex_rs     = ex_rs_q;
   assign ex_rt     = ex_rt_q;
   assign ex_rd     = ex_rd_q;
   assign stall_cnt = stall_cnt_q;

endmodule
